// File: rtl/circular_buffer_arbiter.sv
// circular_buffer_arbiter
// Arbitrates NReq producers (push) and one consumer (pop) onto a single
// circular buffer command port. A shadow occupancy count decides push/pop
// eligibility; pops and pushes alternate under contention and producers are
// served round-robin. All outputs are registered.
// Optional build macro CIRCULAR_BUFFER_ARBITER_CHECK_EN enables a sticky
// consistency check of the shadow count against the buffer's outRemainder.
module circular_buffer_arbiter #(
   parameter int NReq   = 4,
   parameter int NSize  = 3,
   parameter int NWidth = 6
) (
   input  logic                       clock,
   input  logic                       resetN,
   input  logic                       clearReq,
   input  logic [NReq-1:0]            pushReq,
   input  logic [NReq*(NWidth+1)-1:0] pushData,
   output logic [NReq-1:0]            pushGrant,
   input  logic                       popReq,
   output logic                       popGrant,
   output logic [1:0]                 action,
   output logic [NWidth:0]            bufIn,
   input  logic [NSize:0]             outRemainder,
   output logic                       mismatch
);

   localparam int PW     = (NReq > 1) ? $clog2(NReq) : 1;
   localparam int IW     = PW + 1;
   localparam int CapInt = (1 << NSize) - 1;
   localparam logic [NSize:0] CAP = CapInt[NSize:0];

   localparam logic [1:0] ACT_IDLE   = 2'd0;
   localparam logic [1:0] ACT_CLEAR  = 2'd1;
   localparam logic [1:0] ACT_ADD    = 2'd2;
   localparam logic [1:0] ACT_REMOVE = 2'd3;

   typedef enum logic [1:0] {INIT, SETTLE, RUN} state_t;

   state_t            state_reg, state_next;
   logic [NSize:0]    cnt_reg, cnt_next;
   logic [PW-1:0]     rr_ptr_reg, rr_ptr_next;
   logic              last_pop_reg, last_pop_next;
   logic              settle_cnt_reg, settle_cnt_next;
   logic [NReq-1:0]   push_grant_reg, push_grant_next;
   logic              pop_grant_reg, pop_grant_next;
   logic [1:0]        action_reg, action_next;
   logic [NWidth:0]   buf_in_reg, buf_in_next;

   logic [NWidth:0]   data_arr [NReq];
   logic              rr_found;
   logic [PW-1:0]     rr_sel;
   logic [IW-1:0]     rr_idx;
   logic              push_ok;
   logic              pop_ok;

   // unpack each producer's element into its own array entry
   generate
      for (genvar gi = 0; gi < NReq; gi++) begin : g_slice
         assign data_arr[gi] = pushData[gi*(NWidth+1) +: NWidth+1];
      end
   endgenerate

   // round-robin search: first requester after the last granted producer
   always_comb begin
      rr_found = 1'b0;
      rr_sel   = rr_ptr_reg;
      rr_idx   = '0;
      for (int k = 1; k <= NReq; k++) begin
         rr_idx = {1'b0, rr_ptr_reg} + IW'(k);
         if (rr_idx >= IW'(NReq)) begin
            rr_idx = rr_idx - IW'(NReq);
         end
         if (!rr_found && pushReq[rr_idx[PW-1:0]]) begin
            rr_found = 1'b1;
            rr_sel   = rr_idx[PW-1:0];
         end
      end
   end

   // next-state and registered-output decode
   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      rr_ptr_next     = rr_ptr_reg;
      last_pop_next   = last_pop_reg;
      settle_cnt_next = settle_cnt_reg;
      push_grant_next = '0;
      pop_grant_next  = 1'b0;
      action_next     = ACT_IDLE;
      buf_in_next     = buf_in_reg;
      push_ok         = rr_found && (cnt_reg < CAP);
      pop_ok          = popReq && (cnt_reg != '0);

      case (state_reg)
         INIT: begin
            action_next     = ACT_CLEAR;
            cnt_next        = '0;
            last_pop_next   = 1'b0;
            settle_cnt_next = 1'b0;
            state_next      = SETTLE;
         end
         SETTLE: begin
            settle_cnt_next = 1'b1;
            if (settle_cnt_reg) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (clearReq) begin
               // the clear leaves RUN and issues its command on this same
               // edge, so the init step is folded into the transition and
               // the clear appears one cycle after the request like a grant
               action_next     = ACT_CLEAR;
               cnt_next        = '0;
               last_pop_next   = 1'b0;
               settle_cnt_next = 1'b0;
               state_next      = SETTLE;
            end else if (pop_ok && (!push_ok || !last_pop_reg)) begin
               action_next    = ACT_REMOVE;
               pop_grant_next = 1'b1;
               cnt_next       = cnt_reg - 1'b1;
               last_pop_next  = 1'b1;
            end else if (push_ok) begin
               action_next             = ACT_ADD;
               push_grant_next[rr_sel] = 1'b1;
               buf_in_next             = data_arr[rr_sel];
               cnt_next                = cnt_reg + 1'b1;
               rr_ptr_next             = rr_sel;
               last_pop_next           = 1'b0;
            end
         end
         default: begin
            state_next = INIT;
         end
      endcase
   end

   // state and output registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!resetN) begin
         state_reg      <= INIT;
         cnt_reg        <= '0;
         rr_ptr_reg     <= PW'(NReq - 1);
         last_pop_reg   <= 1'b0;
         settle_cnt_reg <= 1'b0;
         push_grant_reg <= '0;
         pop_grant_reg  <= 1'b0;
         action_reg     <= ACT_IDLE;
         buf_in_reg     <= '0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         rr_ptr_reg     <= rr_ptr_next;
         last_pop_reg   <= last_pop_next;
         settle_cnt_reg <= settle_cnt_next;
         push_grant_reg <= push_grant_next;
         pop_grant_reg  <= pop_grant_next;
         action_reg     <= action_next;
         buf_in_reg     <= buf_in_next;
      end
   end

   assign pushGrant = push_grant_reg;
   assign popGrant  = pop_grant_reg;
   assign action    = action_reg;
   assign bufIn     = buf_in_reg;

`ifdef CIRCULAR_BUFFER_ARBITER_CHECK_EN
   logic idle_prev_reg;
   logic mismatch_reg;

   // after two idle commands the buffer has caught up with the shadow count
   always_ff @(posedge clock) begin
      if (!resetN) begin
         idle_prev_reg <= 1'b0;
         mismatch_reg  <= 1'b0;
      end else begin
         idle_prev_reg <= (action_reg == ACT_IDLE);
         if ((state_reg == RUN) && (action_reg == ACT_IDLE) && idle_prev_reg &&
             (cnt_reg != outRemainder)) begin
            mismatch_reg <= 1'b1;
         end
      end
   end

   assign mismatch = mismatch_reg;
`else
   logic unused_remainder;
   assign unused_remainder = ^outRemainder;
   assign mismatch         = 1'b0;
`endif

endmodule

// File: tb/tb_circular_buffer_arbiter.sv
// tb_circular_buffer_arbiter
// Directed stimulus with hand-computed expected transactions pushed into a
// scoreboard; a negedge monitor pops and compares whenever the DUT issues a
// command or an expected entry falls due. Honors CIRCULAR_BUFFER_ARBITER_CHECK_EN.
module tb_circular_buffer_arbiter;

   logic        clock;
   logic        resetN;
   logic        clearReq;
   logic [3:0]  pushReq;
   logic [27:0] pushData;
   logic [3:0]  pushGrant;
   logic        popReq;
   logic        popGrant;
   logic [1:0]  action;
   logic [6:0]  bufIn;
   logic [3:0]  outRemainder;
   logic        mismatch;

   typedef struct {
      int         cyc;
      logic [1:0] act;
      logic [3:0] pg;
      logic       pop;
      logic [6:0] bi;
      logic       mm;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   int         cyc;
   int         checks;
   int         passes;
   logic       exp_mm;
   logic [3:0] occ;
   logic [3:0] bump;

   circular_buffer_arbiter #(.NReq(4), .NSize(3), .NWidth(6)) dut (
      .clock        (clock),
      .resetN       (resetN),
      .clearReq     (clearReq),
      .pushReq      (pushReq),
      .pushData     (pushData),
      .pushGrant    (pushGrant),
      .popReq       (popReq),
      .popGrant     (popGrant),
      .action       (action),
      .bufIn        (bufIn),
      .outRemainder (outRemainder),
      .mismatch     (mismatch)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // behavioural buffer occupancy driven by the issued commands
   initial occ = '0;
   always @(posedge clock) begin
      case (action)
         2'd1:    occ <= '0;
         2'd2:    occ <= occ + 1'b1;
         2'd3:    occ <= occ - 1'b1;
         default: occ <= occ;
      endcase
   end
   assign outRemainder = occ + bump;

   // monitor: compare due entries, flag any command nobody expected
   always @(negedge clock) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         mon_e  = sb.pop_front();
         checks = checks + 1;
         if (action === mon_e.act && pushGrant === mon_e.pg && popGrant === mon_e.pop &&
             bufIn === mon_e.bi && mismatch === mon_e.mm) begin
            passes = passes + 1;
            $display("txn cyc=%0d act=%0d pushGrant=%b popGrant=%b bufIn=%h mismatch=%b ok",
                     cyc, action, pushGrant, popGrant, bufIn, mismatch);
         end else begin
            $display("FAIL txn cyc=%0d: got act=%0d pushGrant=%b popGrant=%b bufIn=%h mismatch=%b, expected act=%0d pushGrant=%b popGrant=%b bufIn=%h mismatch=%b",
                     cyc, action, pushGrant, popGrant, bufIn, mismatch,
                     mon_e.act, mon_e.pg, mon_e.pop, mon_e.bi, mon_e.mm);
         end
      end else if (action !== 2'd0 || pushGrant !== 4'd0 || popGrant !== 1'b0) begin
         checks = checks + 1;
         $display("FAIL unexpected cyc=%0d: got act=%0d pushGrant=%b popGrant=%b, expected no command",
                  cyc, action, pushGrant, popGrant);
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // expect the given outputs after the next rising edge, then advance to it
   task automatic exp_next(input logic [1:0] act, input logic [3:0] pg,
                           input logic pop, input logic [6:0] bi);
      exp_t e;
      e.cyc = cyc + 1;
      e.act = act;
      e.pg  = pg;
      e.pop = pop;
      e.bi  = bi;
      e.mm  = exp_mm;
      sb.push_back(e);
      step();
   endtask

   initial begin
      checks   = 0;
      passes   = 0;
      exp_mm   = 1'b0;
      bump     = '0;
      resetN   = 1'b0;
      clearReq = 1'b0;
      pushReq  = 4'b0000;
      popReq   = 1'b0;
      // producer i element: 0x10, 0x21, 0x32, 0x43
      pushData = {7'h43, 7'h32, 7'h21, 7'h10};

      // reset state
      exp_next(2'd0, 4'b0000, 1'b0, 7'h00);
      exp_next(2'd0, 4'b0000, 1'b0, 7'h00);

      // release with producers 0 and 2 requesting: clear, two idles, then RR
      resetN  = 1'b1;
      pushReq = 4'b0101;
      exp_next(2'd1, 4'b0000, 1'b0, 7'h00);
      exp_next(2'd0, 4'b0000, 1'b0, 7'h00);
      exp_next(2'd0, 4'b0000, 1'b0, 7'h00);
      exp_next(2'd2, 4'b0001, 1'b0, 7'h10);   // cnt 1
      exp_next(2'd2, 4'b0100, 1'b0, 7'h32);   // cnt 2
      exp_next(2'd2, 4'b0001, 1'b0, 7'h10);   // cnt 3
      exp_next(2'd2, 4'b0100, 1'b0, 7'h32);   // cnt 4
      exp_next(2'd2, 4'b0001, 1'b0, 7'h10);   // cnt 5
      exp_next(2'd2, 4'b0100, 1'b0, 7'h32);   // cnt 6
      exp_next(2'd2, 4'b0001, 1'b0, 7'h10);   // cnt 7 (full)
      exp_next(2'd0, 4'b0000, 1'b0, 7'h10);   // full: held, bufIn holds
      exp_next(2'd0, 4'b0000, 1'b0, 7'h10);

      // pop only: 7 -> 2
      pushReq = 4'b0000;
      popReq  = 1'b1;
      for (int i = 0; i < 5; i++) exp_next(2'd3, 4'b0000, 1'b1, 7'h10);

      // single push from producer 3: cnt 3, last action push
      pushReq = 4'b1000;
      popReq  = 1'b0;
      exp_next(2'd2, 4'b1000, 1'b0, 7'h43);

      // contention at cnt 3: pop, push, pop, push
      pushReq = 4'b0001;
      popReq  = 1'b1;
      exp_next(2'd3, 4'b0000, 1'b1, 7'h43);   // cnt 2
      exp_next(2'd2, 4'b0001, 1'b0, 7'h10);   // cnt 3
      exp_next(2'd3, 4'b0000, 1'b1, 7'h10);   // cnt 2
      exp_next(2'd2, 4'b0001, 1'b0, 7'h10);   // cnt 3

      // producer 1 twice: cnt 5
      pushReq = 4'b0010;
      popReq  = 1'b0;
      exp_next(2'd2, 4'b0010, 1'b0, 7'h21);
      exp_next(2'd2, 4'b0010, 1'b0, 7'h21);

      // clear pulse with a pop pending: clear, settle, then empty holds pop
      clearReq = 1'b1;
      pushReq  = 4'b0000;
      popReq   = 1'b1;
      exp_next(2'd1, 4'b0000, 1'b0, 7'h21);
      clearReq = 1'b0;
      for (int i = 0; i < 4; i++) exp_next(2'd0, 4'b0000, 1'b0, 7'h21);

      // producer 1 granted, then a one-cycle reset abandons everything
      popReq  = 1'b0;
      pushReq = 4'b0010;
      exp_next(2'd2, 4'b0010, 1'b0, 7'h21);
      resetN = 1'b0;
      exp_next(2'd0, 4'b0000, 1'b0, 7'h00);
      resetN  = 1'b1;
      pushReq = 4'b0110;
      exp_next(2'd1, 4'b0000, 1'b0, 7'h00);
      exp_next(2'd0, 4'b0000, 1'b0, 7'h00);
      exp_next(2'd0, 4'b0000, 1'b0, 7'h00);
      exp_next(2'd2, 4'b0010, 1'b0, 7'h21);   // pointer restarted: producer 1 first
      exp_next(2'd2, 4'b0100, 1'b0, 7'h32);   // cnt 2
      pushReq = 4'b0000;

`ifdef CIRCULAR_BUFFER_ARBITER_CHECK_EN
      // wrong occupancy report: flagged once two idle commands have passed
      bump = 4'd1;
      exp_next(2'd0, 4'b0000, 1'b0, 7'h32);
      exp_next(2'd0, 4'b0000, 1'b0, 7'h32);
      exp_mm = 1'b1;
      exp_next(2'd0, 4'b0000, 1'b0, 7'h32);
      bump = 4'd0;
      exp_next(2'd0, 4'b0000, 1'b0, 7'h32);   // sticky
      exp_next(2'd0, 4'b0000, 1'b0, 7'h32);
      resetN = 1'b0;
      exp_mm = 1'b0;
      exp_next(2'd0, 4'b0000, 1'b0, 7'h00);
      resetN = 1'b1;
      exp_next(2'd1, 4'b0000, 1'b0, 7'h00);
`else
      exp_next(2'd0, 4'b0000, 1'b0, 7'h32);
      exp_next(2'd0, 4'b0000, 1'b0, 7'h32);
`endif

      // drain: every expected entry must have been consumed
      for (int i = 0; i < 10 && sb.size() != 0; i++) step();
      checks = checks + 1;
      if (sb.size() == 0) begin
         passes = passes + 1;
      end else begin
         $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/circular_buffer_arbiter.md
CIRCULAR_BUFFER_ARBITER -- requirements
Module: circular_buffer_arbiter

Interface
REQ-001 Parameters SHALL be: NReq, default 4, number of producers; NSize, default 3, log2 of buffer slots; NWidth, default 6, element MSB index (element width NWidth+1).
REQ-002 Port clock, input, 1 bit, SHALL be the single clock; every register updates on its rising edge.
REQ-003 Port resetN, input, 1 bit, SHALL be the reset: synchronous, active-low.
REQ-004 Port clearReq, input, 1 bit, SHALL request that the buffer be emptied.
REQ-005 Port pushReq, input, NReq bits, SHALL be the per-producer push request.
REQ-006 Port pushData, input, NReq*(NWidth+1) bits, SHALL carry producer i's element in slice [i*(NWidth+1) +: NWidth+1].
REQ-007 Port pushGrant, output, NReq bits, SHALL be a one-hot push acknowledge.
REQ-008 Port popReq, input, 1 bit, SHALL be the consumer's remove request.
REQ-009 Port popGrant, output, 1 bit, SHALL be the remove acknowledge.
REQ-010 Port action, output, 2 bits, SHALL be the buffer command: 0 idle, 1 clear, 2 add, 3 remove.
REQ-011 Port bufIn, output, NWidth+1 bits, SHALL be the element driven to the buffer with action 2.
REQ-012 Port outRemainder, input, NSize+1 bits, SHALL be the buffer's reported occupancy.
REQ-013 Port mismatch, output, 1 bit, SHALL be the sticky consistency-error flag (see Configuration).

Function
REQ-014 All outputs SHALL be registered; a grant and its action SHALL appear in the same cycle, one cycle after the request is sampled.
REQ-015 The FSM SHALL have the states INIT, SETTLE and RUN.
REQ-016 INIT SHALL drive action=1 for exactly one cycle and then go to SETTLE.
REQ-017 SETTLE SHALL drive action=0 for exactly 2 cycles and then go to RUN.
REQ-018 Shadow count cnt (NSize+1 bits) SHALL be set to 0 in INIT.
REQ-019 In RUN, cnt SHALL increment on each granted push and decrement on each granted pop.
REQ-020 Usable capacity SHALL be CAP=(1<<NSize)-1; a push SHALL be eligible only when cnt<CAP, and a pop only when cnt>0.
REQ-021 At most one action SHALL issue per cycle.
REQ-022 Priority SHALL be: clearReq (RUN to INIT, no grant that cycle), then the pop/push choice below.
REQ-023 When both pop and push are eligible, pop SHALL win unless the previous non-idle action was pop, in which case push SHALL win (alternation).
REQ-024 Producers SHALL be served round-robin: search starts at the index after the last granted producer and wraps from NReq-1 to 0; the pointer updates only on a push grant.
REQ-025 bufIn SHALL equal the granted producer's slice while action=2, and hold its last value otherwise.
REQ-026 Non-granted requests SHALL remain pending; no request SHALL be dropped or queued internally.
REQ-027 pushReq and popReq SHALL be ignored outside RUN.
REQ-028 The push-full condition (cnt==CAP) and the pop-empty condition (cnt==0) SHALL hold requesters without error.

Reset
REQ-029 While resetN=0 at a rising edge, the block SHALL set: state INIT, cnt=0, RR pointer to NReq-1 (producer 0 first), pushGrant=0, popGrant=0, action=0, bufIn=0, mismatch=0, last-action=push.
REQ-030 Reset mid-operation SHALL abandon any in-flight grant; the first cycle after release SHALL drive action=1.

Configuration
REQ-031 With macro CIRCULAR_BUFFER_ARBITER_CHECK_EN defined, the block SHALL compare cnt with outRemainder in RUN whenever the two previous cycles issued action=0, and SHALL set mismatch (cleared only by reset) on inequality.
REQ-032 Without CIRCULAR_BUFFER_ARBITER_CHECK_EN, mismatch SHALL be constant 0 and outRemainder SHALL be unused; all other behaviour SHALL be identical.

Verification
REQ-033 Release reset -> action sequence 1,0,0 then RUN; no grants during INIT or SETTLE.
REQ-034 Producers 0 and 2 push continuously from empty, popReq=0, NSize=3 -> grants alternate 0,2,0,2 until cnt=7; pushGrant then stays 0.
REQ-035 cnt=3 with popReq=1 and pushReq=4'b0001 held -> actions alternate 3,2,3,2 and cnt stays within 2..3.
REQ-036 clearReq pulsed in RUN with cnt=5 -> next action=1, cnt=0, then 2 idle cycles; a pop request then gets no grant.
REQ-037 resetN=0 for one cycle while producer 1 is granted -> all grants 0 next cycle, then action=1.
REQ-038 With CIRCULAR_BUFFER_ARBITER_CHECK_EN, outRemainder forced to cnt+1 while idle -> mismatch=1 after 2 idle cycles and stays 1 until reset.
